// File: rtl/codec_cmd_pkg.sv
// rtl/codec_cmd_pkg.sv - Shared command/response types, FSM states and watchdog sizing for codec_cmd_queue
package codec_cmd_pkg;

    typedef struct packed {
        logic       write;
        logic [7:0] addr;
        logic [7:0] wdata;
    } cmd_t;

    typedef struct packed {
        logic       write;
        logic [7:0] addr;
        logic [7:0] rdata;
        logic       timeout;
        logic       mismatch;
    } rsp_t;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE         = 3'd0;
    localparam state_t S_ISSUE        = 3'd1;
    localparam state_t S_WAIT_BUSY    = 3'd2;
    localparam state_t S_WAIT_DONE    = 3'd3;
    localparam state_t S_VERIFY_ISSUE = 3'd4;
    localparam state_t S_RESP         = 3'd5;

    // Watchdog only has to count up to cycles-1.
    function automatic int wdog_width(input int cycles);
        return (cycles <= 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/codec_cmd_fifo.sv
// rtl/codec_cmd_fifo.sv - Synchronous command FIFO of cmd_t with registered full flag and occupancy level
module codec_cmd_fifo
    import codec_cmd_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_push,
    input  cmd_t                       i_data,
    output logic                       o_full,
    input  logic                       i_pop,
    output cmd_t                       o_data,
    output logic                       o_empty,
    output logic [$clog2(DEPTH+1)-1:0] o_level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    cmd_t          r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;
    logic          r_full;

    logic          w_push;
    logic          w_pop;
    logic [LW-1:0] w_level_nxt;

    assign w_push      = i_push && !r_full;
    assign w_pop       = i_pop && (r_level != '0);
    assign w_level_nxt = r_level + LW'(w_push) - LW'(w_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_full   <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_level <= w_level_nxt;
            r_full  <= (w_level_nxt == LW'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_full  = r_full;
    assign o_empty = (r_level == '0);
    assign o_level = r_level;

endmodule

// File: rtl/codec_cmd_queue.sv
// rtl/codec_cmd_queue.sv - CODEC register command queue: FIFO, issue FSM, watchdog; CODEC_CMD_WRITE_VERIFY_EN adds write read-back
module codec_cmd_queue
    import codec_cmd_pkg::*;
#(
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic                       cmd_write,
    input  logic [7:0]                 cmd_addr,
    input  logic [7:0]                 cmd_wdata,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic                       rsp_write,
    output logic [7:0]                 rsp_addr,
    output logic [7:0]                 rsp_rdata,
    output logic                       rsp_timeout,
    output logic                       rsp_mismatch,
    output logic                       codec_rd_en,
    output logic                       codec_wr_en,
    output logic [7:0]                 codec_reg_addr,
    output logic [7:0]                 codec_data_in,
    input  logic [7:0]                 codec_data_out,
    input  logic                       codec_data_out_valid,
    input  logic                       controller_busy,
    output logic [$clog2(DEPTH+1)-1:0] queue_level,
    output logic                       idle
);
    localparam int            CW        = wdog_width(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] WDOG_LAST = CW'(TIMEOUT_CYCLES - 1);

    state_t        r_state;
    cmd_t          r_cmd;
    logic [7:0]    r_rdata;
    logic          r_timeout;
    logic          r_verify;
    logic [CW-1:0] r_wdog;

    cmd_t          w_cmd_in;
    cmd_t          w_head;
    logic          w_full;
    logic          w_empty;
    logic          w_pop;
    logic          w_wdog_hit;
    logic          w_capture;
    logic          w_mismatch;
    rsp_t          w_rsp;

    assign w_cmd_in = '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata};

    codec_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (cmd_valid),
        .i_data  (w_cmd_in),
        .o_full  (w_full),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_empty (w_empty),
        .o_level (queue_level)
    );

    // The busy check here also keeps a timed-out controller from being re-issued to.
    assign w_pop      = (r_state == S_IDLE) && !w_empty && !controller_busy;
    assign w_wdog_hit = (r_wdog == WDOG_LAST);
    assign w_capture  = codec_data_out_valid && (!r_cmd.write || r_verify);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cmd     <= '0;
            r_rdata   <= '0;
            r_timeout <= 1'b0;
            r_verify  <= 1'b0;
            r_wdog    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_cmd     <= w_head;
                        r_rdata   <= '0;
                        r_timeout <= 1'b0;
                        r_verify  <= 1'b0;
                        r_state   <= S_ISSUE;
                    end
                end
                S_ISSUE, S_VERIFY_ISSUE: begin
                    r_wdog  <= '0;
                    r_state <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    if (w_wdog_hit) begin
                        r_timeout <= 1'b1;
                        r_rdata   <= '0;
                        r_state   <= S_RESP;
                    end else begin
                        r_wdog <= r_wdog + CW'(1);
                        if (controller_busy) r_state <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    if (w_capture) r_rdata <= codec_data_out;
                    // Completion takes priority over a watchdog expiring in the same cycle.
                    if (!controller_busy) begin
`ifdef CODEC_CMD_WRITE_VERIFY_EN
                        if (r_cmd.write && !r_verify) begin
                            r_verify <= 1'b1;
                            r_state  <= S_VERIFY_ISSUE;
                        end else begin
                            r_state  <= S_RESP;
                        end
`else
                        r_state <= S_RESP;
`endif
                    end else if (w_wdog_hit) begin
                        r_timeout <= 1'b1;
                        r_rdata   <= '0;
                        r_state   <= S_RESP;
                    end else begin
                        r_wdog <= r_wdog + CW'(1);
                    end
                end
                S_RESP: begin
                    if (rsp_ready) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef CODEC_CMD_WRITE_VERIFY_EN
    logic       r_mismatch;
    logic [7:0] w_rd_val;

    assign w_rd_val = w_capture ? codec_data_out : r_rdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mismatch <= 1'b0;
        end else if (w_pop) begin
            r_mismatch <= 1'b0;
        end else if (r_state == S_WAIT_DONE && !controller_busy && r_verify) begin
            r_mismatch <= (w_rd_val != r_cmd.wdata);
        end
    end

    assign w_mismatch = r_mismatch;
`else
    assign w_mismatch = 1'b0;
`endif

    assign w_rsp = '{write: r_cmd.write, addr: r_cmd.addr, rdata: r_rdata,
                     timeout: r_timeout, mismatch: w_mismatch};

    assign cmd_ready      = !w_full;
    assign rsp_valid      = (r_state == S_RESP);
    assign rsp_write      = w_rsp.write;
    assign rsp_addr       = w_rsp.addr;
    assign rsp_rdata      = w_rsp.rdata;
    assign rsp_timeout    = w_rsp.timeout;
    assign rsp_mismatch   = w_rsp.mismatch;
    assign codec_rd_en    = ((r_state == S_ISSUE) && !r_cmd.write) || (r_state == S_VERIFY_ISSUE);
    assign codec_wr_en    = (r_state == S_ISSUE) && r_cmd.write;
    assign codec_reg_addr = r_cmd.addr;
    assign codec_data_in  = r_cmd.wdata;
    assign idle           = w_empty && (r_state == S_IDLE);

endmodule

// File: tb/tb_codec_cmd_queue.sv
// tb/tb_codec_cmd_queue.sv - Directed self-checking bench for codec_cmd_queue with a behavioural CODEC controller
module tb_codec_cmd_queue;
    localparam int DEPTH = 4;
    localparam int TO    = 50;
`ifdef CODEC_CMD_WRITE_VERIFY_EN
    localparam bit VER = 1'b1;
`else
    localparam bit VER = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid, cmd_ready, cmd_write;
    logic [7:0] cmd_addr, cmd_wdata;
    logic       rsp_valid, rsp_ready, rsp_write, rsp_timeout, rsp_mismatch;
    logic [7:0] rsp_addr, rsp_rdata;
    logic       codec_rd_en, codec_wr_en;
    logic [7:0] codec_reg_addr, codec_data_in, codec_data_out;
    logic       codec_data_out_valid, controller_busy;
    logic [2:0] queue_level;
    logic       idle;

    always #5 clk = ~clk;

    codec_cmd_queue #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_addr(rsp_addr), .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout),
        .rsp_mismatch(rsp_mismatch),
        .codec_rd_en(codec_rd_en), .codec_wr_en(codec_wr_en),
        .codec_reg_addr(codec_reg_addr), .codec_data_in(codec_data_in),
        .codec_data_out(codec_data_out), .codec_data_out_valid(codec_data_out_valid),
        .controller_busy(controller_busy), .queue_level(queue_level), .idle(idle)
    );

    // Controller model: busy for busy_len cycles after a pulse, read data valid on the last busy cycle.
    int         busy_len = 20;
    bit         force_busy = 1'b0;
    bit         corrupt = 1'b0;
    int         m_cnt = 0;
    bit         m_read = 1'b0;
    logic [7:0] m_data = 8'h00;
    logic [7:0] mem [256];
    bit         written [256];

    always @(posedge clk) begin
        if (codec_wr_en) begin
            mem[codec_reg_addr]     <= codec_data_in;
            written[codec_reg_addr] <= 1'b1;
            m_cnt  <= busy_len;
            m_read <= 1'b0;
        end else if (codec_rd_en) begin
            m_cnt  <= busy_len;
            m_read <= 1'b1;
            m_data <= (written[codec_reg_addr] ? mem[codec_reg_addr] : (codec_reg_addr ^ 8'hA2))
                      ^ {7'd0, corrupt};
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
        end
    end

    assign controller_busy      = force_busy || (m_cnt != 0);
    assign codec_data_out_valid = m_read && (m_cnt == 1);
    assign codec_data_out       = m_data;

    int         n_rd = 0;
    int         n_wr = 0;
    logic [7:0] wr_log [64];

    always @(negedge clk) begin
        if (codec_rd_en) n_rd <= n_rd + 1;
        if (codec_wr_en) begin
            wr_log[n_wr % 64] <= codec_reg_addr;
            n_wr <= n_wr + 1;
        end
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic w, input logic [7:0] a, input logic [7:0] d);
        int t = 0;
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        while (!cmd_ready && t < 2000) begin @(negedge clk); t++; end
        chk("push_accept", 32'(t < 2000), 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic get_rsp(input string tag, input logic w, input logic [7:0] a,
                           input logic [7:0] d, input logic to, input logic mm);
        int t = 0;
        while (!rsp_valid && t < 3000) begin @(negedge clk); t++; end
        chk(tag, 32'({rsp_valid, rsp_write, rsp_addr, rsp_rdata, rsp_timeout, rsp_mismatch}),
                 32'({1'b1, w, a, d, to, mm}));
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout bench did not reach its summary");
        $fatal(1, "bench timeout");
    end

    initial begin
        int rd0, wr0, lat, t, pulses, bad, early, seen;
        reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 8'h00;
        cmd_wdata = 8'h00; rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready_level_idle", 32'({cmd_ready, queue_level, idle}), 32'({1'b1, 3'd0, 1'b1}));
        chk("rst_rsp", 32'({rsp_valid, rsp_write, rsp_addr, rsp_rdata, rsp_timeout, rsp_mismatch}), 32'd0);
        chk("rst_codec", 32'({codec_rd_en, codec_wr_en, codec_reg_addr, codec_data_in}), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Held in init: nothing issues while busy, one pulse once busy drops.
        force_busy = 1'b1;
        push(1'b0, 8'h07, 8'h00);
        rd0 = n_rd;
        repeat (500) @(negedge clk);
        chk("init_no_issue", 32'(n_rd - rd0), 32'd0);
        chk("init_level", 32'(queue_level), 32'd1);
        force_busy = 1'b0;
        pulses = 0;
        repeat (2) begin @(negedge clk); if (codec_rd_en) pulses++; end
        chk("init_issue_pulse", 32'(pulses), 32'd1);
        get_rsp("init_read", 1'b0, 8'h07, 8'hA5, 1'b0, 1'b0);

        // Single read and push-to-issue latency.
        push(1'b0, 8'h07, 8'h00);
        lat = 1;
        while (!codec_rd_en && lat < 20) begin @(negedge clk); lat++; end
        chk("push_to_issue_latency", 32'(lat), 32'd2);
        get_rsp("single_read", 1'b0, 8'h07, 8'hA5, 1'b0, 1'b0);

        // Burst of six writes into a four-entry queue.
        force_busy = 1'b1;
        for (int i = 0; i < 4; i++) push(1'b1, 8'(8'h10 + i), 8'(8'h80 + i));
        chk("full_level_ready", 32'({queue_level, cmd_ready}), 32'({3'd4, 1'b0}));
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h14; cmd_wdata = 8'h84;
        repeat (3) @(negedge clk);
        chk("full_push_ignored", 32'(queue_level), 32'd4);
        cmd_valid = 1'b0;
        wr0 = n_wr;
        force_busy = 1'b0;
        fork
            for (int i = 4; i < 6; i++) push(1'b1, 8'(8'h10 + i), 8'(8'h80 + i));
            for (int j = 0; j < 6; j++)
                get_rsp("burst_rsp", 1'b1, 8'(8'h10 + j), VER ? 8'(8'h80 + j) : 8'h00, 1'b0, 1'b0);
        join
        chk("burst_issue_count", 32'(n_wr - wr0), 32'd6);
        for (int k = 0; k < 6; k++)
            chk("burst_issue_order", 32'(wr_log[(wr0 + k) % 64]), 32'(8'h10 + k));
        repeat (40) @(negedge clk);
        chk("burst_no_extra_rsp", 32'({rsp_valid, idle}), 32'({1'b0, 1'b1}));

        // Response backpressure.
        push(1'b0, 8'h21, 8'h00);
        push(1'b1, 8'h22, 8'h5A);
        t = 0;
        while (!rsp_valid && t < 2000) begin @(negedge clk); t++; end
        rd0 = n_rd; wr0 = n_wr; bad = 0;
        repeat (100) begin
            @(negedge clk);
            if ({rsp_valid, rsp_write, rsp_addr, rsp_rdata, rsp_timeout} !==
                {1'b1, 1'b0, 8'h21, 8'h83, 1'b0}) bad++;
        end
        chk("bp_unstable_cycles", 32'(bad), 32'd0);
        chk("bp_no_pulses", 32'((n_rd - rd0) + (n_wr - wr0)), 32'd0);
        get_rsp("bp_read", 1'b0, 8'h21, 8'h83, 1'b0, 1'b0);
        get_rsp("bp_write", 1'b1, 8'h22, VER ? 8'h5A : 8'h00, 1'b0, 1'b0);

        // Watchdog with busy stuck high.
        busy_len = 200;
        push(1'b0, 8'h30, 8'h00);
        t = 0;
        while (!codec_rd_en && t < 20) begin @(negedge clk); t++; end
        lat = 0;
        while (!rsp_valid && lat < 200) begin @(negedge clk); if (!rsp_valid) lat++; end
        chk("timeout_latency", 32'(lat), 32'(TO));
        push(1'b0, 8'h31, 8'h00);
        busy_len = 20;
        get_rsp("timeout_rsp", 1'b0, 8'h30, 8'h00, 1'b1, 1'b0);
        early = 0; t = 0;
        while (controller_busy && t < 400) begin @(negedge clk); if (codec_rd_en) early++; t++; end
        chk("timeout_hold_off", 32'(early), 32'd0);
        get_rsp("after_timeout", 1'b0, 8'h31, 8'h93, 1'b0, 1'b0);

        // Completion on the watchdog's last cycle wins; one cycle later it times out.
        busy_len = 49;
        push(1'b0, 8'h40, 8'h00);
        get_rsp("edge_complete", 1'b0, 8'h40, 8'hE2, 1'b0, 1'b0);
        busy_len = 50;
        push(1'b0, 8'h41, 8'h00);
        get_rsp("edge_timeout", 1'b0, 8'h41, 8'h00, 1'b1, 1'b0);
        busy_len = 20;

        // Write followed by a corrupted read-back.
        corrupt = 1'b1;
        push(1'b1, 8'h02, 8'h3C);
        get_rsp("verify_write", 1'b1, 8'h02, VER ? 8'h3D : 8'h00, 1'b0, VER);
        corrupt = 1'b0;

        // Asynchronous reset while a command is in flight and another is queued.
        push(1'b0, 8'h50, 8'h00);
        push(1'b0, 8'h51, 8'h00);
        t = 0;
        while (!codec_rd_en && t < 40) begin @(negedge clk); t++; end
        #2 reset = 1'b1;
        #1 chk("midrst_state", 32'({codec_rd_en, idle, cmd_ready, queue_level}),
                               32'({1'b0, 1'b1, 1'b1, 3'd0}));
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        repeat (60) begin @(negedge clk); if (rsp_valid || codec_rd_en) seen++; end
        chk("midrst_no_activity", 32'(seen), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/codec_cmd_queue.md
Name: codec_cmd_queue

Overview:
- Upstream command front-end for the CODEC controller unit.
- Accepts CODEC register read/write requests from the processor-side register block through a valid/ready interface and buffers them in a small FIFO.
- Issues the requests one at a time on the controller's rd_en/wr_en/addr/data port and returns each result, with a timeout flag, on a valid/ready response channel.
- The processor can queue a whole register sequence without polling controller_busy.

Parameters:
- DEPTH, 4: command FIFO entries; must be a power of 2 and at least 2.
- TIMEOUT_CYCLES, 1000000: per-command watchdog limit in clk cycles.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  FIFO not full.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  8  CODEC register address.
- cmd_wdata  in  8  write data.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_write  out  1  echo of the command type.
- rsp_addr  out  8  echo of the address.
- rsp_rdata  out  8  read data; 0 for writes and timeouts.
- rsp_timeout  out  1  command hit the watchdog.
- rsp_mismatch  out  1  write-verify failure; see Optional Feature.
- codec_rd_en  out  1  one-cycle read pulse to the controller.
- codec_wr_en  out  1  one-cycle write pulse to the controller.
- codec_reg_addr  out  8  address to the controller.
- codec_data_in  out  8  write data to the controller.
- codec_data_out  in  8  read data from the controller.
- codec_data_out_valid  in  1  read data qualifier.
- controller_busy  in  1  controller busy; also high during CODEC init.
- queue_level  out  $clog2(DEPTH+1)  FIFO occupancy.
- idle  out  1  FIFO empty, FSM in IDLE and rsp_valid low.

Behaviour:
- Reset (async, active-high): FIFO empty, FSM enters IDLE, watchdog counter cleared. Output reset values:
  - All rsp_* outputs, codec_rd_en, codec_wr_en, codec_reg_addr, codec_data_in: 0.
  - cmd_ready: 1.
  - queue_level: 0.
  - idle: 1.
- Reset mid-operation drops any in-flight command; no response is generated for it.
- FIFO rules:
  - Push when cmd_valid && cmd_ready. cmd_ready = !full, a registered flag.
  - Push and pop in the same cycle are both honoured.
  - A push while full is ignored (blocked by cmd_ready). No bypass path: minimum latency from push to issue is 2 cycles.
- FSM states and transitions:
  - IDLE: if FIFO not empty and controller_busy == 0, pop the head into the command register and go to ISSUE.
  - ISSUE: drive codec_rd_en or codec_wr_en high for exactly 1 cycle. addr/data are held stable from ISSUE until the command completes. Clear the watchdog, go to WAIT_BUSY.
  - WAIT_BUSY: wait for controller_busy == 1, then go to WAIT_DONE.
  - WAIT_DONE: for a read, capture codec_data_out into rsp_rdata on any cycle where codec_data_out_valid == 1 (last capture wins). When controller_busy == 0, go to RESP.
  - RESP: assert rsp_valid with rsp_write, rsp_addr and rsp_rdata. Hold all of them stable until rsp_ready. On the handshake cycle, return to IDLE. A new issue can occur the following cycle.
- Watchdog:
  - The counter runs in WAIT_BUSY and WAIT_DONE.
  - At TIMEOUT_CYCLES-1, go to RESP with rsp_timeout = 1 and rsp_rdata = 0.
  - The FIFO is not flushed. IDLE's busy check prevents re-issuing while the controller is still busy.
- Simultaneous events:
  - busy rising and data_out_valid in the same cycle as ISSUE: busy is sampled from WAIT_BUSY onward, so a busy level already high is accepted.
  - A read completing on the exact timeout cycle: completion wins, rsp_timeout = 0.
- rsp_rdata is cleared when leaving IDLE.
- queue_level updates one cycle after a push or pop.

Optional Feature:
- Macro: CODEC_CMD_WRITE_VERIFY_EN.
- Defined: after a write completes without timeout, the FSM auto-issues a read of the same address through the same ISSUE/WAIT_BUSY/WAIT_DONE path, before RESP.
  - The single response reports rsp_write = 1, rsp_rdata = the read-back value, and rsp_mismatch = (read-back != written data).
  - A timeout during the verify read sets rsp_timeout = 1 and rsp_mismatch = 0.
- Undefined: no verify read; rsp_mismatch is tied to 0.

Decomposition:
- Package codec_cmd_pkg:
  - cmd_t struct {write, addr[7:0], wdata[7:0]}.
  - rsp_t struct {write, addr, rdata, timeout, mismatch}.
  - State enum: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, VERIFY_ISSUE, RESP.
  - Watchdog counter width constant.
- Sub-module codec_cmd_fifo: synchronous FIFO of cmd_t, DEPTH entries, with full/empty/level outputs.

Test Plan:
- Held in init: controller_busy = 1 for 500 cycles with one read queued -> no rd_en pulse; after busy falls, one rd_en pulse within 2 cycles.
- Single read: read addr 0x07; controller model returns 0xA5 with valid, busy high 20 cycles -> rsp_valid with rsp_addr = 0x07, rsp_rdata = 0xA5, rsp_timeout = 0, rsp_write = 0.
- Burst and full: 6 writes back-to-back with DEPTH = 4 and a busy controller -> cmd_ready low when queue_level = 4; all 6 issued in order; exactly 6 responses.
- Response backpressure: rsp_ready held low 100 cycles -> rsp_* stable throughout; no further rd_en/wr_en pulses until the handshake.
- Timeout: TIMEOUT_CYCLES = 50, busy stuck high after issue -> response at 50 cycles with rsp_timeout = 1, rsp_rdata = 0; next command issues only after busy falls.
- With CODEC_CMD_WRITE_VERIFY_EN: write 0x3C to 0x02, model reads back 0x3D -> one response with rsp_mismatch = 1, rsp_rdata = 0x3D.
